// File: rtl/serial_mult_pkg.sv
// Shared types and constants for the serial shift-add multiplier.
package serial_mult_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        BUSY   = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/serial_mult_dp.sv
// Datapath for serial_mult: operand shift registers, accumulator and bit counter.
module serial_mult_dp
    import serial_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_a_i,
    input  logic               load_b_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load_a_i) begin
            a_d = {{WIDTH{1'b0}}, data_i};
        end
        // The accumulator is only cleared when B arrives, so the last product
        // stays visible through IDLE and the loading of A.
        if (load_b_i) begin
            b_d   = data_i;
            acc_d = '0;
            cnt_d = '0;
        end else if (step_i) begin
            if (b_q[0]) begin
                acc_d = acc_q + a_q;
            end
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_LAST);
    assign prod_o = acc_q;

endmodule

// File: rtl/serial_mult.sv
// Unsigned serial multiplier: two put transfers load A then B, one multiplier
// bit per clock, product held until acknowledged with get.
module serial_mult
    import serial_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               put,
    input  logic               get,
    input  logic [WIDTH-1:0]   idata,
    output logic               ready,
    output logic               result_valid,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e state_q, state_d;
    logic   load_a, load_b, step, last;

    assign load_a = (state_q == IDLE) && put;
    assign load_b = (state_q == LOAD_B) && put;
    assign step   = (state_q == BUSY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (put)  state_d = LOAD_B;
            LOAD_B:  if (put)  state_d = BUSY;
            BUSY:    if (last) state_d = DONE;
            DONE:    if (get)  state_d = IDLE;
            default:           state_d = IDLE;
        endcase
    end

    // rst_b is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    serial_mult_dp #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_dp (
        .clk_i    (clk),
        .rst_i    (rst_b),
        .load_a_i (load_a),
        .load_b_i (load_b),
        .step_i   (step),
        .data_i   (idata),
        .last_o   (last),
        .prod_o   (result)
    );

    assign ready        = (state_q == IDLE) || (state_q == LOAD_B);
    assign result_valid = (state_q == DONE);

endmodule

// File: tb/tb_serial_mult.sv
// Directed bench for serial_mult: hand-computed products, handshake timing and reset abort.
module tb_serial_mult;

    logic        clk;
    logic        rst_b;
    logic        put;
    logic        get;
    logic [7:0]  idata;
    logic        ready;
    logic        result_valid;
    logic [15:0] result;

    logic [15:0] exp_q[$];
    int          n_total;
    int          n_bad;

    serial_mult #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .put          (put),
        .get          (get),
        .idata        (idata),
        .ready        (ready),
        .result_valid (result_valid),
        .result       (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic put_op(input logic [7:0] v);
        int waited;
        waited = 0;
        while (!ready && waited < 20) begin
            tick();
            waited++;
        end
        check("put_ready", {31'd0, ready}, 32'd1);
        put   = 1'b1;
        idata = v;
        tick();
        put   = 1'b0;
    endtask

    // Loads both operands and checks the exact BUSY latency and the product.
    task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        logic [15:0] want;
        exp_q.push_back(exp);
        put_op(a);
        put_op(b);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 1) check("busy_ready", {31'd0, ready}, 32'd0);
            if (i == 7) check("early_valid", {31'd0, result_valid}, 32'd0);
        end
        want = exp_q.pop_front();
        check("valid", {31'd0, result_valid}, 32'd1);
        check("product", {16'd0, result}, {16'd0, want});
    endtask

    task automatic ack();
        get = 1'b1;
        tick();
        get = 1'b0;
        check("ack_valid", {31'd0, result_valid}, 32'd0);
        check("ack_ready", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_b   = 1'b1;
        put     = 1'b0;
        get     = 1'b0;
        idata   = 8'd0;
        tick();
        tick();
        rst_b = 1'b0;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);

        // Basic product and release
        run_mult(8'd5, 8'd5, 16'd25);
        ack();
        check("hold_after_get", {16'd0, result}, 32'd25);

        // get while idle does nothing
        get = 1'b1;
        tick();
        get = 1'b0;
        check("idle_get_ready", {31'd0, ready}, 32'd1);
        check("idle_get_valid", {31'd0, result_valid}, 32'd0);

        // put held for three cycles; get pulsed mid-BUSY
        exp_q.push_back(16'd25);
        put   = 1'b1;
        idata = 8'd5;
        tick();
        tick();
        tick();
        put = 1'b0;
        check("held_put_busy", {31'd0, ready}, 32'd0);
        tick();
        get = 1'b1;
        tick();
        get = 1'b0;
        check("busy_get_ignored", {31'd0, result_valid}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("held_valid", {31'd0, result_valid}, 32'd1);
        check("held_product", {16'd0, result}, {16'd0, exp_q.pop_front()});
        tick();
        tick();
        check("done_hold_valid", {31'd0, result_valid}, 32'd1);
        check("done_hold_result", {16'd0, result}, 32'd25);
        ack();

        // Boundary operands
        run_mult(8'd255, 8'd255, 16'hFE01);
        ack();
        run_mult(8'd0, 8'd200, 16'd0);
        ack();
        run_mult(8'd1, 8'd128, 16'd128);
        ack();
        run_mult(8'd128, 8'd2, 16'd256);
        ack();

        // Reset in the 4th BUSY cycle discards the computation
        put_op(8'd10);
        put_op(8'd10);
        tick();
        tick();
        tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_valid", {31'd0, result_valid}, 32'd0);
        check("abort_result", {16'd0, result}, 32'd0);
        run_mult(8'd3, 8'd7, 16'd21);

        // get and put together in DONE: put must not be captured
        put   = 1'b1;
        get   = 1'b1;
        idata = 8'd77;
        tick();
        put = 1'b0;
        get = 1'b0;
        check("both_valid", {31'd0, result_valid}, 32'd0);
        check("both_ready", {31'd0, ready}, 32'd1);
        run_mult(8'd9, 8'd9, 16'd81);
        ack();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
